// File: rtl/mux_pipeline_stream.sv
// Streaming N:1 multiplexer built as a radix-RADIX reduction tree with one elastic
// register stage per tree level; the select and an out-of-range flag travel with each beat.
module mux_pipeline_stream #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned INPUT_COUNT = 10,
    parameter int unsigned RADIX       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(INPUT_COUNT)-1:0] in_sel,
    input  logic [WIDTH*INPUT_COUNT-1:0]   in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [$clog2(INPUT_COUNT)-1:0] out_sel,
    output logic                           out_err,
    output logic                           busy
);

    // Integer power; non-positive exponents give 1.
    function automatic int ipow(input int base, input int e);
        int p;
        p = 1;
        for (int j = 0; j < e; j++) begin
            p = p * base;
        end
        return p;
    endfunction

    // Smallest s >= 1 with r**s >= n.
    function automatic int calc_stages(input int n, input int r);
        int s;
        int span;
        s    = 1;
        span = r;
        while (span < n) begin
            span = span * r;
            s    = s + 1;
        end
        return s;
    endfunction

    localparam int unsigned SEL_W    = $clog2(INPUT_COUNT);
    localparam int unsigned RSEL_W   = $clog2(RADIX);
    localparam int unsigned STAGES   = calc_stages(INPUT_COUNT, RADIX);
    localparam int unsigned PAD      = ipow(RADIX, STAGES);
    localparam int unsigned SELP_W   = STAGES * RSEL_W;
    localparam int unsigned ST_WORDS = (PAD - 1) / (RADIX - 1);
    localparam int unsigned OUT_IDX  = ST_WORDS - 1;

    // Words held by stage s (stage 0 is the widest, the last stage holds one).
    function automatic int stage_words(input int s);
        return ipow(RADIX, STAGES - 1 - s);
    endfunction

    // Word offset of stage s inside the flat stage storage; negative s gives 0.
    function automatic int stage_off(input int s);
        int off;
        off = 0;
        for (int j = 0; j < s; j++) begin
            off = off + stage_words(j);
        end
        return off;
    endfunction

    logic [STAGES-1:0]         vld;
    logic [STAGES-1:0]         st_err;
    logic [STAGES*SEL_W-1:0]   st_sel;
    logic [ST_WORDS*WIDTH-1:0] st_words;

    logic [STAGES-1:0]         up_v;
    logic [STAGES-1:0]         up_err;
    logic [STAGES*SEL_W-1:0]   up_sel;
    logic [STAGES-1:0]         load;
    logic [STAGES-1:0]         adv;
    logic [ST_WORDS*WIDTH-1:0] words_d;
    logic [PAD*WIDTH-1:0]      pad_in;
    logic                      in_err;
    logic [SELP_W-1:0]         sel_p;
    logic [RSEL_W-1:0]         grp;
    logic [WIDTH-1:0]          word;

    assign pad_in = (PAD*WIDTH)'(in_data);
    assign in_err = (32'(in_sel) >= INPUT_COUNT);

    // Upstream view of each stage: the input port for stage 0, the previous stage otherwise.
    always_comb begin
        up_v              = '0;
        up_sel            = '0;
        up_err            = '0;
        up_v[0]           = in_valid && !rst;
        up_sel[SEL_W-1:0] = in_sel;
        up_err[0]         = in_err;
        for (int s = 1; s < STAGES; s++) begin
            up_v[s]                  = vld[s-1];
            up_sel[s*SEL_W +: SEL_W] = st_sel[(s-1)*SEL_W +: SEL_W];
            up_err[s]                = st_err[s-1];
        end
    end

    // Elastic handshake resolved from the output back toward the input in one cycle.
    always_comb begin
        load          = '0;
        adv           = '0;
        adv[STAGES-1] = out_ready;
        for (int s = int'(STAGES) - 1; s >= 0; s--) begin
            load[s] = up_v[s] && (!vld[s] || adv[s]);
            if (s > 0) begin
                adv[s-1] = load[s];
            end
        end
    end

    assign in_ready = !rst && (!vld[0] || adv[0]);

    // Per-unit RADIX:1 selection; out-of-range beats are zeroed at the first level.
    always_comb begin
        words_d = st_words;
        sel_p   = '0;
        grp     = '0;
        word    = '0;
        for (int s = 0; s < STAGES; s++) begin
            sel_p = SELP_W'(up_sel[s*SEL_W +: SEL_W]);
            grp   = sel_p[s*RSEL_W +: RSEL_W];
            for (int u = 0; u < PAD / RADIX; u++) begin
                if (load[s] && (u < stage_words(s))) begin
                    if (s == 0) begin
                        word = in_err ? '0 : pad_in[(u*RADIX + int'(grp))*WIDTH +: WIDTH];
                    end else begin
                        word = st_words[(stage_off(s - 1) + u*RADIX + int'(grp))*WIDTH +: WIDTH];
                    end
                    words_d[(stage_off(s) + u)*WIDTH +: WIDTH] = word;
                end
            end
        end
    end

    // Stage registers: load from upstream, or drop valid when the beat moves on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld      <= '0;
            st_sel   <= '0;
            st_err   <= '0;
            st_words <= '0;
        end else begin
            st_words <= words_d;
            for (int s = 0; s < STAGES; s++) begin
                if (load[s]) begin
                    vld[s]                   <= 1'b1;
                    st_sel[s*SEL_W +: SEL_W] <= up_sel[s*SEL_W +: SEL_W];
                    st_err[s]                <= up_err[s];
                end else if (adv[s]) begin
                    vld[s] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign out_data  = st_words[OUT_IDX*WIDTH +: WIDTH];
    assign out_sel   = st_sel[(STAGES-1)*SEL_W +: SEL_W];
    assign out_err   = st_err[STAGES-1];
    assign busy      = |vld;

endmodule

// File: tb/tb_mux_pipeline_stream.sv
// Bench for mux_pipeline_stream: default instance (RADIX 4, 10 inputs) and a RADIX 2 / 5 input instance.
`timescale 1ns/1ps
module tb_mux_pipeline_stream;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 10;
    localparam int unsigned N2 = 5;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] s;
        logic       e;
    } beat_t;

    logic clk;
    logic rst;

    logic           in_valid, in_ready, out_valid, out_ready, out_err, busy;
    logic [3:0]     in_sel, out_sel;
    logic [W*N-1:0] in_data;
    logic [7:0]     out_data;

    logic            in_valid2, in_ready2, out_valid2, out_ready2, out_err2, busy2;
    logic [2:0]      in_sel2, out_sel2;
    logic [W*N2-1:0] in_data2;
    logic [7:0]      out_data2;

    int    checks   = 0;
    int    failures = 0;
    beat_t q[$];

    mux_pipeline_stream dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .out_err(out_err), .busy(busy)
    );

    mux_pipeline_stream #(.WIDTH(8), .INPUT_COUNT(5), .RADIX(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_sel(in_sel2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_sel(out_sel2), .out_err(out_err2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the beat the mux must eventually deliver for a given select and input vector.
    function automatic beat_t ref_beat(input logic [3:0] s, input logic [W*N-1:0] data);
        beat_t b;
        b.s = s;
        b.e = (int'(s) >= int'(N));
        b.d = b.e ? 8'h00 : data[int'(s)*W +: W];
        return b;
    endfunction

    // One cycle on the default instance: drive, sample mid-cycle, record accepted beats.
    task automatic drive(input logic v, input logic [3:0] s, input logic ordy,
                         output logic ir, output logic ov, output beat_t ob, output logic bz);
        in_valid  = v;
        in_sel    = s;
        out_ready = ordy;
        #2;
        ir   = in_ready;
        ov   = out_valid;
        ob.d = out_data;
        ob.s = out_sel;
        ob.e = out_err;
        bz   = busy;
        if (v && ir) q.push_back(ref_beat(s, in_data));
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = '0; out_ready = 1'b1;
        in_valid2 = 1'b0; in_sel2 = '0; out_ready2 = 1'b1;
        set_default_data();
        for (int i = 0; i < N2; i++) in_data2[i*W +: W] = 8'hA0 + 8'(i);
        #3;
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
        if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
        if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data: got %h exp 00", out_data); end
        if (out_sel !== 4'd0)   begin failures++; $display("FAIL reset_out_sel: got %0d exp 0", out_sel); end
        if (out_err !== 1'b0)   begin failures++; $display("FAIL reset_out_err: got %b exp 0", out_err); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        logic ir, ov, bz; beat_t ob, ex;
        int first_ov = -1, last_ov = -1, n_out = 0;
        for (int i = 0; i < 14; i++) begin
            drive(i < 10, 4'(i), 1'b1, ir, ov, ob, bz);
            if (i < 10) begin
                checks++;
                if (ir !== 1'b1) begin failures++; $display("FAIL stream_in_ready: cycle %0d got %b exp 1", i, ir); end
            end
            if (ov) begin
                if (first_ov < 0) first_ov = i;
                last_ov = i;
                n_out++;
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL stream_extra: unexpected sel=%0d", ob.s); end
                else begin
                    ex = q.pop_front();
                    if (ob !== ex) begin failures++; $display("FAIL stream_beat: got d=%h s=%0d e=%b exp d=%h s=%0d e=%b", ob.d, ob.s, ob.e, ex.d, ex.s, ex.e); end
                end
            end
        end
        checks += 3;
        if (first_ov !== 2) begin failures++; $display("FAIL stream_latency: first out at %0d exp 2", first_ov); end
        if (n_out !== 10 || last_ov - first_ov !== 9) begin failures++; $display("FAIL stream_gaps: count %0d span %0d exp 10/9", n_out, last_ov - first_ov); end
        if (q.size() !== 0) begin failures++; $display("FAIL stream_left: %0d beats missing exp 0", q.size()); end
    endtask

    task automatic test_backpressure();
        logic ir, ov, bz; beat_t ob, ex;
        logic pending = 1'b1;
        int n_out = 0;
        logic [2:0] exp_ir = 3'b011;
        int sels[3] = '{3, 7, 9};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(sels[i]), 1'b0, ir, ov, ob, bz);
            checks++;
            if (ir !== exp_ir[i]) begin failures++; $display("FAIL bp_in_ready: beat %0d got %b exp %b", i, ir, exp_ir[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'd9, 1'b0, ir, ov, ob, bz);
            checks++;
            if (ov !== 1'b1 || ob.d !== 8'hA3 || ob.s !== 4'd3 || ir !== 1'b0) begin
                failures++; $display("FAIL bp_hold: got v=%b d=%h s=%0d ir=%b exp v=1 d=a3 s=3 ir=0", ov, ob.d, ob.s, ir);
            end
        end
        for (int i = 0; i < 8; i++) begin
            drive(pending, 4'd9, 1'b1, ir, ov, ob, bz);
            if (i == 0) begin
                checks++;
                if (ir !== 1'b1) begin failures++; $display("FAIL bp_release_accept: got %b exp 1", ir); end
            end
            if (pending && ir) pending = 1'b0;
            if (ov) begin
                n_out++;
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL bp_extra: unexpected sel=%0d", ob.s); end
                else begin
                    ex = q.pop_front();
                    if (ob !== ex) begin failures++; $display("FAIL bp_beat: got d=%h s=%0d e=%b exp d=%h s=%0d e=%b", ob.d, ob.s, ob.e, ex.d, ex.s, ex.e); end
                end
            end
        end
        checks++;
        if (n_out !== 3) begin failures++; $display("FAIL bp_count: got %0d exp 3", n_out); end
    endtask

    task automatic test_out_of_range();
        logic ir, ov, bz; beat_t ob, ex;
        int n_out = 0;
        for (int i = 0; i < 6; i++) begin
            drive(i < 2, (i == 0) ? 4'd12 : 4'd5, 1'b1, ir, ov, ob, bz);
            if (ov) begin
                n_out++;
                checks++;
                if (n_out == 1 && (ob.e !== 1'b1 || ob.d !== 8'h00 || ob.s !== 4'd12)) begin
                    failures++; $display("FAIL err_beat: got d=%h s=%0d e=%b exp d=00 s=12 e=1", ob.d, ob.s, ob.e);
                end
                if (q.size() == 0) begin failures++; $display("FAIL err_extra: unexpected sel=%0d", ob.s); end
                else begin
                    ex = q.pop_front();
                    if (ob !== ex) begin failures++; $display("FAIL err_seq: got d=%h s=%0d e=%b exp d=%h s=%0d e=%b", ob.d, ob.s, ob.e, ex.d, ex.s, ex.e); end
                end
            end
        end
        checks++;
        if (n_out !== 2) begin failures++; $display("FAIL err_count: got %0d exp 2", n_out); end
    endtask

    task automatic test_bubble();
        logic ir, ov, bz; beat_t ob, ex;
        int n_out = 0;
        logic [9:0] vv = 10'b0000000101;
        logic [9:0] rr = 10'b1111101000;
        for (int i = 0; i < 10; i++) begin
            drive(vv[i], (i == 0) ? 4'd6 : 4'd2, rr[i], ir, ov, ob, bz);
            if (i == 2) begin
                checks++;
                if (ir !== 1'b1 || bz !== 1'b1) begin failures++; $display("FAIL bubble_fill: got ir=%b busy=%b exp 1/1", ir, bz); end
            end
            if (ov && rr[i]) begin
                n_out++;
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL bubble_dup: unexpected sel=%0d", ob.s); end
                else begin
                    ex = q.pop_front();
                    if (ob !== ex) begin failures++; $display("FAIL bubble_beat: got d=%h s=%0d exp d=%h s=%0d", ob.d, ob.s, ex.d, ex.s); end
                end
            end
            if (i == 9) begin
                checks++;
                if (bz !== 1'b0) begin failures++; $display("FAIL bubble_busy: got %b exp 0", bz); end
            end
        end
        checks++;
        if (n_out !== 2) begin failures++; $display("FAIL bubble_count: got %0d exp 2", n_out); end
    endtask

    task automatic test_async_reset();
        logic ir, ov, bz; beat_t ob, ex;
        drive(1'b1, 4'd1, 1'b1, ir, ov, ob, bz);
        drive(1'b1, 4'd2, 1'b1, ir, ov, ob, bz);
        in_valid = 1'b1; in_sel = 4'd4; out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL async_reset: got v=%b busy=%b ir=%b exp 0/0/0", out_valid, busy, in_ready);
        end
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 4'd8, 1'b1, ir, ov, ob, bz);
            checks++;
            if (i == 0 && ir !== 1'b1) begin failures++; $display("FAIL rst_accept: got %b exp 1", ir); end
            if (ov !== (i == 2)) begin failures++; $display("FAIL rst_out_valid: cycle %0d got %b exp %b", i, ov, (i == 2)); end
            if (ov) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rst_extra: unexpected sel=%0d", ob.s); end
                else begin
                    ex = q.pop_front();
                    if (ob !== ex) begin failures++; $display("FAIL rst_beat: got d=%h s=%0d exp d=%h s=%0d", ob.d, ob.s, ex.d, ex.s); end
                end
            end
        end
    endtask

    task automatic test_random();
        logic ir, ov, bz, v, ordy; beat_t ob, ex;
        logic [3:0] s;
        int qs, bad_ir = 0, bad_bz = 0;
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                for (int w = 0; w < N; w++) in_data[w*W +: W] = 8'($urandom);
                v    = ($urandom_range(0, 3) != 0);
                s    = 4'($urandom_range(0, 15));
                ordy = ($urandom_range(0, 2) != 0);
            end else begin
                v = 1'b0; s = '0; ordy = 1'b1;
            end
            qs = q.size();
            drive(v, s, ordy, ir, ov, ob, bz);
            checks += 2;
            if (ir !== (qs < 2 || ordy)) begin
                failures++; bad_ir++;
                if (bad_ir < 5) $display("FAIL rand_in_ready: cycle %0d got %b exp %b", i, ir, (qs < 2 || ordy));
            end
            if (bz !== (qs != 0)) begin
                failures++; bad_bz++;
                if (bad_bz < 5) $display("FAIL rand_busy: cycle %0d got %b exp %b", i, bz, (qs != 0));
            end
            if (ov && ordy) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL rand_extra: unexpected sel=%0d", ob.s); end
                else begin
                    ex = q.pop_front();
                    if (ob !== ex) begin failures++; $display("FAIL rand_beat: got d=%h s=%0d e=%b exp d=%h s=%0d e=%b", ob.d, ob.s, ob.e, ex.d, ex.s, ex.e); end
                end
            end
        end
        checks++;
        if (q.size() !== 0) begin failures++; $display("FAIL rand_left: %0d beats missing exp 0", q.size()); end
        set_default_data();
    endtask

    task automatic test_radix2();
        int sels[6] = '{0, 1, 2, 3, 4, 7};
        int qsel[$];
        int qcyc[$];
        int n_out = 0, es, ec;
        logic [7:0] ed;
        for (int i = 0; i < 11; i++) begin
            in_valid2  = (i < 6);
            in_sel2    = (i < 6) ? 3'(sels[i]) : 3'd0;
            out_ready2 = 1'b1;
            #2;
            if (i < 6) begin
                checks++;
                if (in_ready2 !== 1'b1) begin failures++; $display("FAIL r2_in_ready: cycle %0d got %b exp 1", i, in_ready2); end
                if (in_ready2) begin qsel.push_back(sels[i]); qcyc.push_back(i); end
            end
            if (out_valid2) begin
                n_out++;
                checks++;
                if (qsel.size() == 0) begin failures++; $display("FAIL r2_extra: unexpected sel=%0d", out_sel2); end
                else begin
                    es = qsel.pop_front();
                    ec = qcyc.pop_front();
                    ed = (es < int'(N2)) ? 8'hA0 + 8'(es) : 8'h00;
                    if (out_data2 !== ed || int'(out_sel2) !== es || out_err2 !== (es >= int'(N2)) || i !== ec + 3) begin
                        failures++;
                        $display("FAIL r2_beat: got d=%h s=%0d e=%b at %0d exp d=%h s=%0d e=%b at %0d",
                                 out_data2, out_sel2, out_err2, i, ed, es, (es >= int'(N2)), ec + 3);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_out !== 6 || busy2 !== 1'b0) begin failures++; $display("FAIL r2_count: got %0d busy=%b exp 6 busy=0", n_out, busy2); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_bubble();
        test_async_reset();
        test_random();
        test_radix2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
